iterative_muldiv_unit: RTL and testbench

//  Multi-cycle unsigned multiply/divide unit for the execute stage. Consumes the two

---
 rtl/iterative_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_iterative_muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/iterative_muldiv_unit.sv
// Iterative unsigned multiply/divide unit, one result bit per clock.
// Shift-add multiply and restoring divide share one {hi,lo} register pair;
// the finished result is presented as a one-cycle register-file write request.
module iterative_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic [REGADDR-1:0] dest,
  input  logic               abort,
  output logic               busy,
  output logic               wb_regwrite,
  output logic [REGADDR-1:0] wb_writereg,
  output logic [WIDTH-1:0]   wb_writedata
);

  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier shifting out, product low half / quotient
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [1:0]         op_q, op_d;
  logic [REGADDR-1:0] dest_q, dest_d;
  logic               busy_q, busy_d;
  logic               wb_regwrite_q, wb_regwrite_d;
  logic [REGADDR-1:0] wb_writereg_q, wb_writereg_d;
  logic [WIDTH-1:0]   wb_writedata_q, wb_writedata_d;

  logic [WIDTH:0]     mul_sum_s;        // hi + (lo[0] ? opa : 0) with carry
  logic [WIDTH:0]     div_shift_s;      // {rem, quo msb}: remainder shifted left by one
  logic               div_fit_s;        // trial subtraction does not borrow

  // Next-state, datapath step and output-register computation.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    opa_d          = opa_q;
    opb_d          = opb_q;
    op_d           = op_q;
    dest_d         = dest_q;
    busy_d         = busy_q;
    wb_regwrite_d  = 1'b0;
    wb_writereg_d  = wb_writereg_q;
    wb_writedata_d = wb_writedata_q;

    mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_q, lo_q[WIDTH-1]};
    div_fit_s   = (div_shift_s >= {1'b0, opb_q});

    case (state_q)
      S_IDLE: begin
        // start wins over abort here; abort has no meaning while idle
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          op_d    = op;
          dest_d  = dest;
          opa_d   = opa;
          opb_d   = opb;
          cnt_d   = CNT_LAST;
          hi_d    = {WIDTH{1'b0}};
          lo_d    = op[1] ? opa : opb;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          if (op_q[1]) begin
            // restoring divide: a zero divisor always fits, giving all-ones / opa
            if (div_fit_s) begin
              hi_d = div_shift_s[WIDTH-1:0] - opb_q;
              lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_d = div_shift_s[WIDTH-1:0];
              lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            // shift {carry,hi,lo} right by one after the conditional add
            hi_d = mul_sum_s[WIDTH:1];
            lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == {CNTW{1'b0}}) begin
            state_d = S_WB;
          end else begin
            cnt_d = cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
      end
      S_WB: begin
        // MULLO/DIVQ live in lo, MULHI/DIVR in hi
        state_d        = S_IDLE;
        busy_d         = 1'b0;
        wb_regwrite_d  = 1'b1;
        wb_writereg_d  = dest_q;
        wb_writedata_d = op_q[0] ? hi_q : lo_q;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= {CNTW{1'b0}};
      hi_q           <= {WIDTH{1'b0}};
      lo_q           <= {WIDTH{1'b0}};
      opa_q          <= {WIDTH{1'b0}};
      opb_q          <= {WIDTH{1'b0}};
      op_q           <= 2'b00;
      dest_q         <= {REGADDR{1'b0}};
      busy_q         <= 1'b0;
      wb_regwrite_q  <= 1'b0;
      wb_writereg_q  <= {REGADDR{1'b0}};
      wb_writedata_q <= {WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      op_q           <= op_d;
      dest_q         <= dest_d;
      busy_q         <= busy_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_writereg_q  <= wb_writereg_d;
      wb_writedata_q <= wb_writedata_d;
    end
  end

  assign busy         = busy_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign wb_writereg  = wb_writereg_q;
  assign wb_writedata = wb_writedata_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Self-checking bench for iterative_muldiv_unit: directed corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_iterative_muldiv_unit;

  localparam int W   = 32;
  localparam int RA  = 5;
  localparam int LAT = W + 1;   // edges from accepting start to the edge raising the strobe
  localparam int IVL = W + 2;   // issue interval

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [RA-1:0] dest;
  logic          abort;
  logic          busy;
  logic          wb_regwrite;
  logic [RA-1:0] wb_writereg;
  logic [W-1:0]  wb_writedata;

  int checks = 0;
  int errors = 0;

  iterative_muldiv_unit #(.WIDTH(W), .REGADDR(RA)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .dest(dest), .abort(abort), .busy(busy), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_writedata(wb_writedata)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit product, plain / and % with the divide-by-zero rule.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one op from idle and check latency, index, data and single-cycle strobe.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [RA-1:0] d);
    int n;
    @(negedge clock);
    op = o; opa = a; opb = b; dest = d; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!wb_regwrite && n < 80) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(LAT));
    check_eq({tag, "_reg"}, 64'(wb_writereg), 64'(d));
    check_eq({tag, "_data"}, 64'(wb_writedata), 64'(model(o, a, b)));
    @(posedge clock); #1;
    check_eq({tag, "_strobe_off"}, 64'(wb_regwrite), 64'd0);
    check_eq({tag, "_held"}, 64'(wb_writedata), 64'(model(o, a, b)));
  endtask

  // Count strobes over a window of cycles.
  task automatic count_strobes(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      if (wb_regwrite) cnt++;
    end
  endtask

  logic [W-1:0] q_exp[$];
  logic [RA-1:0] q_dst[$];

  initial begin
    int cnt;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'd0; opa = '0; opb = '0; dest = '0;
    #12;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_we", 64'(wb_regwrite), 64'd0);
    check_eq("rst_reg", 64'(wb_writereg), 64'd0);
    check_eq("rst_data", 64'(wb_writedata), 64'd0);
    @(negedge clock); reset = 1'b0;

    // Test 2/3/4: directed results
    do_op("mullo_7x6", 2'd0, 32'd7, 32'd6, 5'd3);
    do_op("mulhi_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    do_op("mullo_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    do_op("divq_100_7", 2'd2, 32'd100, 32'd7, 5'd4);
    do_op("divr_100_7", 2'd3, 32'd100, 32'd7, 5'd4);
    do_op("divq_5_0", 2'd2, 32'd5, 32'd0, 5'd0);
    do_op("divr_5_0", 2'd3, 32'd5, 32'd0, 5'd31);

    // Test 1: reset at cycle 10 of MULLO 7*6 clears outputs immediately, no strobe
    @(negedge clock);
    op = 2'd0; opa = 32'd7; opb = 32'd6; dest = 5'd3; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (9) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_we", 64'(wb_regwrite), 64'd0);
    check_eq("midrst_reg", 64'(wb_writereg), 64'd0);
    check_eq("midrst_data", 64'(wb_writedata), 64'd0);
    @(negedge clock); reset = 1'b0;
    count_strobes(2 * IVL, cnt);
    check_eq("midrst_nostrobe", 64'(cnt), 64'd0);

    // Test 6: abort in RUN cycle 5, then a fresh op completes correctly
    @(negedge clock);
    op = 2'd1; opa = $urandom; opb = $urandom; dest = 5'd7; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    count_strobes(2 * IVL, cnt);
    check_eq("abort_nostrobe", 64'(cnt), 64'd0);
    do_op("after_abort", 2'd2, 32'd1000, 32'd33, 5'd12);

    // abort while idle with start: start wins
    @(negedge clock);
    op = 2'd0; opa = 32'd11; opb = 32'd13; dest = 5'd2; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1; start = 1'b0; abort = 1'b0;
    check_eq("start_wins", 64'(busy), 64'd1);
    count_strobes(IVL, cnt);
    check_eq("start_wins_strobe", 64'(cnt), 64'd1);
    check_eq("start_wins_data", 64'(wb_writedata), 64'd143);

    // Randomized single ops
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      do_op("rand", ro, ra, rb, 5'($urandom));
    end

    // Test 5: start held high every cycle with changing operands
    cnt = 0;
    for (int k = 0; k < 3 * IVL; k++) begin
      @(negedge clock);
      op = 2'($urandom_range(0, 3)); opa = $urandom; opb = $urandom; dest = 5'($urandom);
      start = 1'b1;
      if (k % IVL == 0) begin
        q_exp.push_back(model(op, opa, opb));
        q_dst.push_back(dest);
      end
      @(posedge clock); #1;
      check_eq("b2b_busy", 64'(busy), (k % IVL == LAT) ? 64'd0 : 64'd1);
      if (wb_regwrite) begin
        cnt++;
        check_eq("b2b_slot", 64'(k % IVL), 64'(LAT));
        if (q_exp.size() > 0) begin
          check_eq("b2b_data", 64'(wb_writedata), 64'(q_exp.pop_front()));
          check_eq("b2b_reg", 64'(wb_writereg), 64'(q_dst.pop_front()));
        end
      end
    end
    @(negedge clock); start = 1'b0;
    check_eq("b2b_count", 64'(cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
